pkt_seq_ctrl: RTL
=================

// Module: pkt_seq_ctrl
// PURPOSE
//  Packet sequencer after the header path. Per packet: forward header bytes, then code-block bodies in order;
//  one code-block per entry on the length stream. Merges both onto one AXI-Stream packet output for the
//  codestream writer. Counts packets and flags length/body mismatches.
// PARAMETERS
//  DATA_W         128       data width of hdr, body and output streams (multiple of 8)
//  KEEP_W         DATA_W/8  byte-enable width
//  LENGTH_DATA_W  32        code-block body length in bytes
//  PKT_IDX_W      16        packet counter width
// PORTS
//  clk                   in   1              clock, all logic on posedge
//  rst_n                 in   1              async active-low reset
//  s_axis_hdr_rx_valid_i/_last_i/_data_i/_keep_i  in  1/1/DATA_W/KEEP_W  header bytes; last = end of header
//  s_axis_hdr_rx_ready_o out  1              header ready
//  s_axis_len_rx_valid_i/_last_i/_data_i          in  1/1/LENGTH_DATA_W  body length; last = final cb of packet
//  s_axis_len_rx_ready_o out  1              length ready
//  s_axis_body_rx_valid_i/_last_i/_data_i/_keep_i in  1/1/DATA_W/KEEP_W  body bytes; last = end of code-block
//  s_axis_body_rx_ready_o out  1              body ready
//  m_axis_pkt_tx_valid_o/_last_o/_data_o/_keep_o  out 1/1/DATA_W/KEEP_W  packet out; last = end of packet
//  m_axis_pkt_tx_ready_i in   1              downstream ready
//  pkt_index_o           out  PKT_IDX_W      count of completed packets; wraps to 0
//  pkt_done_o            out  1              1-cycle pulse when the last beat of a packet is accepted
//  err_len_o             out  1              sticky; clears only on reset
// BEHAVIOUR
//  Reset: all outputs and *_ready_o 0; state IDLE; counters 0.
//  Keep: contiguous from the LSB byte. Bytes in a beat = popcount(keep).
//  Output register: one stage. Loads when !m_valid || m_ready. Data held stable while valid && !ready.
//    Latency input->output is 1 cycle. Only one *_ready_o is high at a time, selected by state.
//  States:
//   IDLE  wait len_valid; pop first length into rem_cnt and len_last_r -> HDR.
//         Empty packet = first entry len==0 with last=1.
//   HDR   hdr_ready = out stage free; forward beats. On hdr last: if empty packet, beat has m_last=1 -> DONE;
//         if rem_cnt==0 otherwise (non-final zero-length entry) -> LEN; else -> BODY.
//   BODY  forward body beats; rem_cnt -= popcount(keep), saturating at 0.
//         Code-block ends when body last is accepted. m_last = len_last_r on that beat.
//         Ends -> DONE if len_last_r, else LEN.
//   LEN   pop next length. If len==0: skip the entry and stay in LEN, or go to DONE if last.
//         If len==0 && last && the packet has no body beats pending, emit a null beat: keep=0, last=1.
//         Else -> BODY.
//   DONE  when the last beat is accepted: pkt_done_o=1, pkt_index_o+=1 -> IDLE.
//  Errors that set err_len_o (sequencing continues):
//   - body last while rem_cnt != popcount(keep)
//   - zero-length entry that is not the sole entry of an empty packet
//  rem_cnt is LENGTH_DATA_W wide; no overflow possible.
//  Simultaneous: body last and m_ready on the same cycle -> state advances that cycle; no bubble required.
//  Reset mid-packet: returns to IDLE at once; partial output beat dropped; upstreams must also be reset.
// CONFIGURATION
//  PKT_SEQ_BYTE_CNT_EN defined:
//   - extra output pkt_bytes_o [LENGTH_DATA_W]: total bytes (hdr+body) of the last completed packet.
//   - updates on the pkt_done_o cycle; reset 0.
//  Undefined: port absent; no counter logic.
// STRUCTURE
//  Shared header j2k_pkt_defs.vh: state encodings (IDLE/HDR/BODY/LEN/DONE), popcount function,
//    PKT_IDX_W default.
//  One sub-module: axis_out_reg, the output register slice with data/keep/last hold.
//  FSM and counters live in pkt_seq_ctrl.
// TESTING
//  1 Empty pkt: len=0/last=1; hdr 2 beats (keep FFFF,00FF) -> out 2 beats, last on beat 2; index 0->1;
//    err 0.
//  2 Two code-blocks: len 20,16(last); body 16+4 B, 16 B -> hdr beats, then 3 body beats;
//    last only on the 16 B beat; err 0.
//  3 Backpressure: m_ready toggles 1/0 every cycle through test 2 -> identical output, no dropped
//    or duplicated beats.
//  4 Mismatch: len=20, body 16+8 B with last -> err_len_o=1 sticky; next packet still sequenced correctly.
//  5 Zero-length middle cb: len 8,0,8(last) -> err_len_o=1; output hdr + 8 B + 8 B; last on final beat.
//  6 Reset asserted during BODY -> all outputs 0 next edge; after release a clean packet passes;
//    pkt_index_o = 1.

Source files
------------

// File: rtl/pkt_seq_ctrl_pkg.sv
// Shared definitions for the packet sequencer: FSM state encoding, byte
// popcount helper and default packet-index width.
package pkt_seq_ctrl_pkg;

  localparam int unsigned PKT_IDX_W_DEF = 16;
  localparam int unsigned MAX_KEEP_W    = 128;
  localparam int unsigned POP_W         = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    BODY = 3'd2,
    LEN  = 3'd3,
    DONE = 3'd4
  } state_e;

  // Number of set bits in a keep vector (zero-extended to MAX_KEEP_W).
  function automatic logic [POP_W-1:0] popcount(input logic [MAX_KEEP_W-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_KEEP_W; i++) begin
      n = n + POP_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream output register slice.
// Ports: in_* load side (free_c = slice can accept this cycle),
//        out_* registered stream towards the downstream consumer.
// Payload is held stable while out_valid && !out_ready.
module axis_out_reg #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned KEEP_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEEP_W-1:0] in_keep,
  input  logic              in_last,
  output logic              free_c,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [KEEP_W-1:0] out_keep,
  output logic              out_last,
  input  logic              out_ready
);

  assign free_c = !out_valid || out_ready;

  // Load a new beat whenever the slot is empty or being drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
    end else if (free_c) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
        out_keep <= in_keep;
        out_last <= in_last;
      end
    end
  end

endmodule

// File: rtl/pkt_seq_ctrl.sv
// Packet sequencer: per packet forwards header beats, then one code-block
// body per entry of the length stream, merged onto one AXI-Stream output.
// Ports: s_axis_hdr_rx_*  header stream (last = end of header)
//        s_axis_len_rx_*  code-block lengths (last = final entry of packet)
//        s_axis_body_rx_* code-block bodies (last = end of code-block)
//        m_axis_pkt_tx_*  packet output (last = end of packet)
//        pkt_index_o      completed packet count (wraps)
//        pkt_done_o       pulse when a packet's last beat has been accepted
//        err_len_o        sticky length/body mismatch flag
//        pkt_bytes_o      byte total of the last packet (PKT_SEQ_BYTE_CNT_EN only)
// Build option: define PKT_SEQ_BYTE_CNT_EN to add the pkt_bytes_o counter.
module pkt_seq_ctrl
  import pkt_seq_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W        = 128,
  parameter int unsigned KEEP_W        = DATA_W / 8,
  parameter int unsigned LENGTH_DATA_W = 32,
  parameter int unsigned PKT_IDX_W     = PKT_IDX_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_axis_hdr_rx_valid_i,
  input  logic                     s_axis_hdr_rx_last_i,
  input  logic [DATA_W-1:0]        s_axis_hdr_rx_data_i,
  input  logic [KEEP_W-1:0]        s_axis_hdr_rx_keep_i,
  output logic                     s_axis_hdr_rx_ready_o,
  input  logic                     s_axis_len_rx_valid_i,
  input  logic                     s_axis_len_rx_last_i,
  input  logic [LENGTH_DATA_W-1:0] s_axis_len_rx_data_i,
  output logic                     s_axis_len_rx_ready_o,
  input  logic                     s_axis_body_rx_valid_i,
  input  logic                     s_axis_body_rx_last_i,
  input  logic [DATA_W-1:0]        s_axis_body_rx_data_i,
  input  logic [KEEP_W-1:0]        s_axis_body_rx_keep_i,
  output logic                     s_axis_body_rx_ready_o,
  output logic                     m_axis_pkt_tx_valid_o,
  output logic                     m_axis_pkt_tx_last_o,
  output logic [DATA_W-1:0]        m_axis_pkt_tx_data_o,
  output logic [KEEP_W-1:0]        m_axis_pkt_tx_keep_o,
  input  logic                     m_axis_pkt_tx_ready_i,
  output logic [PKT_IDX_W-1:0]     pkt_index_o,
  output logic                     pkt_done_o,
  output logic                     err_len_o
`ifdef PKT_SEQ_BYTE_CNT_EN
  ,
  output logic [LENGTH_DATA_W-1:0] pkt_bytes_o
`endif
);

  state_e                   state, state_n;
  logic [LENGTH_DATA_W-1:0] rem_cnt, rem_cnt_n;
  logic                     len_last_r, len_last_n;
  logic                     empty_r, empty_n;
  logic                     run_r;
  logic                     err_set_c;
  logic                     done_c;
  logic                     out_free_c;
  logic                     ld_valid_c;
  logic                     ld_last_c;
  logic [DATA_W-1:0]        ld_data_c;
  logic [KEEP_W-1:0]        ld_keep_c;
  logic [LENGTH_DATA_W-1:0] body_bytes_c;
  logic                     hdr_fire_c, len_fire_c, body_fire_c, out_last_acc_c;

  // run_r keeps the length port closed while reset is (or was just) active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_r <= 1'b0;
    else        run_r <= 1'b1;
  end

  assign s_axis_hdr_rx_ready_o  = (state == HDR)  && out_free_c;
  assign s_axis_body_rx_ready_o = (state == BODY) && out_free_c;
  assign s_axis_len_rx_ready_o  = ((state == IDLE) && run_r) || ((state == LEN) && out_free_c);

  assign hdr_fire_c     = s_axis_hdr_rx_valid_i  && s_axis_hdr_rx_ready_o;
  assign len_fire_c     = s_axis_len_rx_valid_i  && s_axis_len_rx_ready_o;
  assign body_fire_c    = s_axis_body_rx_valid_i && s_axis_body_rx_ready_o;
  assign out_last_acc_c = m_axis_pkt_tx_valid_o && m_axis_pkt_tx_ready_i && m_axis_pkt_tx_last_o;
  assign body_bytes_c   = LENGTH_DATA_W'(popcount(MAX_KEEP_W'(s_axis_body_rx_keep_i)));

  // State register and per-packet context.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rem_cnt    <= '0;
      len_last_r <= 1'b0;
      empty_r    <= 1'b0;
    end else begin
      state      <= state_n;
      rem_cnt    <= rem_cnt_n;
      len_last_r <= len_last_n;
      empty_r    <= empty_n;
    end
  end

  // Next-state, output-stage load and error detection.
  always_comb begin
    state_n    = state;
    rem_cnt_n  = rem_cnt;
    len_last_n = len_last_r;
    empty_n    = empty_r;
    err_set_c  = 1'b0;
    done_c     = 1'b0;
    ld_valid_c = 1'b0;
    ld_data_c  = s_axis_hdr_rx_data_i;
    ld_keep_c  = s_axis_hdr_rx_keep_i;
    ld_last_c  = 1'b0;
    unique case (state)
      IDLE: begin
        if (len_fire_c) begin
          rem_cnt_n  = s_axis_len_rx_data_i;
          len_last_n = s_axis_len_rx_last_i;
          empty_n    = (s_axis_len_rx_data_i == '0) && s_axis_len_rx_last_i;
          // A leading zero-length entry is only legal as the sole entry.
          if ((s_axis_len_rx_data_i == '0) && !s_axis_len_rx_last_i) err_set_c = 1'b1;
          state_n    = HDR;
        end
      end
      HDR: begin
        if (hdr_fire_c) begin
          ld_valid_c = 1'b1;
          ld_last_c  = s_axis_hdr_rx_last_i && empty_r;
          if (s_axis_hdr_rx_last_i) begin
            if (empty_r)              state_n = DONE;
            else if (rem_cnt == '0)   state_n = LEN;
            else                      state_n = BODY;
          end
        end
      end
      BODY: begin
        if (body_fire_c) begin
          ld_valid_c = 1'b1;
          ld_data_c  = s_axis_body_rx_data_i;
          ld_keep_c  = s_axis_body_rx_keep_i;
          ld_last_c  = s_axis_body_rx_last_i && len_last_r;
          rem_cnt_n  = (rem_cnt > body_bytes_c) ? (rem_cnt - body_bytes_c) : '0;
          if (s_axis_body_rx_last_i) begin
            if (rem_cnt != body_bytes_c) err_set_c = 1'b1;
            state_n = len_last_r ? DONE : LEN;
          end
        end
      end
      LEN: begin
        if (len_fire_c) begin
          if (s_axis_len_rx_data_i == '0) begin
            err_set_c = 1'b1;
            // Final entry carries no bytes: close the packet with a null beat.
            if (s_axis_len_rx_last_i) begin
              ld_valid_c = 1'b1;
              ld_data_c  = '0;
              ld_keep_c  = '0;
              ld_last_c  = 1'b1;
              state_n    = DONE;
            end
          end else begin
            rem_cnt_n  = s_axis_len_rx_data_i;
            len_last_n = s_axis_len_rx_last_i;
            state_n    = BODY;
          end
        end
      end
      DONE: begin
        if (out_last_acc_c) begin
          done_c  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Packet counter, done pulse and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_index_o <= '0;
      pkt_done_o  <= 1'b0;
      err_len_o   <= 1'b0;
    end else begin
      pkt_done_o <= done_c;
      if (done_c)    pkt_index_o <= pkt_index_o + PKT_IDX_W'(1);
      if (err_set_c) err_len_o   <= 1'b1;
    end
  end

`ifdef PKT_SEQ_BYTE_CNT_EN
  logic [LENGTH_DATA_W-1:0] byte_acc;

  // Accumulate bytes of every loaded beat; publish on packet completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_acc    <= '0;
      pkt_bytes_o <= '0;
    end else if (done_c) begin
      pkt_bytes_o <= byte_acc;
      byte_acc    <= '0;
    end else if (ld_valid_c) begin
      byte_acc <= byte_acc + LENGTH_DATA_W'(popcount(MAX_KEEP_W'(ld_keep_c)));
    end
  end
`endif

  axis_out_reg #(
    .DATA_W (DATA_W),
    .KEEP_W (KEEP_W)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (ld_valid_c),
    .in_data   (ld_data_c),
    .in_keep   (ld_keep_c),
    .in_last   (ld_last_c),
    .free_c    (out_free_c),
    .out_valid (m_axis_pkt_tx_valid_o),
    .out_data  (m_axis_pkt_tx_data_o),
    .out_keep  (m_axis_pkt_tx_keep_o),
    .out_last  (m_axis_pkt_tx_last_o),
    .out_ready (m_axis_pkt_tx_ready_i)
  );

endmodule
